// File: rtl/sdrc_req_arb.sv
// sdrc_req_arb: two-port round-robin arbiter in front of the SDRAM
// bus-width converter. One request is granted at a time; the winner's
// address, length, direction and dma_last are latched and presented
// downstream until acknowledged. Write-next and read-valid beats are
// then routed to the owner until the burst's last beat.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   rN_req*           requester N (0/1) request bundle, held until ack
//   rN_req_ack        one-cycle acceptance pulse to requester N
//   rN_wr_data/en_n   requester N write data and active-low byte enables
//   rN_wr_next        write beat consumed, owner only
//   rN_rd_data/valid  read data (broadcast) and valid (owner only)
//   app_req*          latched request towards the converter
//   app_req_ack       downstream acceptance
//   app_wr_*          owner's write data/enables, downstream write beat
//   app_rd_*          downstream read data and valid
module sdrc_req_arb #(
   parameter int APP_AW = 30,
   parameter int APP_DW = 32,
   parameter int APP_BW = 4,
   parameter int APP_RW = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              r0_req,
   input  logic [APP_AW-1:0] r0_req_addr,
   input  logic [APP_RW-1:0] r0_req_len,
   input  logic              r0_req_wr_n,
   input  logic              r0_req_dma_last,
   output logic              r0_req_ack,
   input  logic [APP_DW-1:0] r0_wr_data,
   input  logic [APP_BW-1:0] r0_wr_en_n,
   output logic              r0_wr_next,
   output logic [APP_DW-1:0] r0_rd_data,
   output logic              r0_rd_valid,
   input  logic              r1_req,
   input  logic [APP_AW-1:0] r1_req_addr,
   input  logic [APP_RW-1:0] r1_req_len,
   input  logic              r1_req_wr_n,
   input  logic              r1_req_dma_last,
   output logic              r1_req_ack,
   input  logic [APP_DW-1:0] r1_wr_data,
   input  logic [APP_BW-1:0] r1_wr_en_n,
   output logic              r1_wr_next,
   output logic [APP_DW-1:0] r1_rd_data,
   output logic              r1_rd_valid,
   output logic              app_req,
   output logic [APP_AW-1:0] app_req_addr,
   output logic [APP_RW-1:0] app_req_len,
   output logic              app_req_wr_n,
   output logic              app_req_dma_last,
   input  logic              app_req_ack,
   output logic [APP_DW-1:0] app_wr_data,
   output logic [APP_BW-1:0] app_wr_en_n,
   input  logic              app_wr_next,
   input  logic [APP_DW-1:0] app_rd_data,
   input  logic              app_rd_valid
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_XFER = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic [APP_AW-1:0] addr_q, addr_d;
   logic [APP_RW-1:0] len_q, len_d;
   logic              wr_n_q, wr_n_d;
   logic              dma_q, dma_d;
   logic [APP_RW-1:0] cnt_q, cnt_d;

   logic gnt;
   logic in_req;
   logic wr_phase;
   logic rd_phase;
   logic beat;
   logic ack_hit;

   // Tie goes to the port that did not finish the previous burst.
   assign gnt = (r0_req & r1_req) ? ~last_q : r1_req;

   assign in_req   = (state_q == S_REQ);
   assign wr_phase = (state_q == S_XFER) & ~wr_n_q;
   assign rd_phase = (state_q == S_XFER) & wr_n_q;
   assign beat     = (wr_phase & app_wr_next) | (rd_phase & app_rd_valid);
   assign ack_hit  = in_req & app_req_ack;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      addr_d  = addr_q;
      len_d   = len_q;
      wr_n_d  = wr_n_q;
      dma_d   = dma_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (r0_req | r1_req) begin
               owner_d = gnt;
               addr_d  = gnt ? r1_req_addr : r0_req_addr;
               len_d   = gnt ? r1_req_len : r0_req_len;
               wr_n_d  = gnt ? r1_req_wr_n : r0_req_wr_n;
               dma_d   = gnt ? r1_req_dma_last : r0_req_dma_last;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (app_req_ack) begin
               // Zero-length bursts still move one beat.
               cnt_d   = (len_q == '0) ? APP_RW'(1) : len_q;
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            if (beat) begin
               cnt_d = cnt_q - APP_RW'(1);
               if (cnt_q == APP_RW'(1)) begin
                  state_d = S_IDLE;
                  last_d  = owner_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         addr_q  <= '0;
         len_q   <= '0;
         wr_n_q  <= 1'b1;
         dma_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         wr_n_q  <= wr_n_d;
         dma_q   <= dma_d;
         cnt_q   <= cnt_d;
      end
   end

   assign app_req          = in_req;
   assign app_req_addr     = addr_q;
   assign app_req_len      = len_q;
   assign app_req_wr_n     = wr_n_q;
   assign app_req_dma_last = dma_q;

   assign r0_req_ack = ack_hit & ~owner_q;
   assign r1_req_ack = ack_hit & owner_q;

   assign app_wr_data = owner_q ? r1_wr_data : r0_wr_data;
   assign app_wr_en_n = ~wr_phase ? '1 :
                        (owner_q ? r1_wr_en_n : r0_wr_en_n);

   assign r0_wr_next  = wr_phase & ~owner_q & app_wr_next;
   assign r1_wr_next  = wr_phase & owner_q & app_wr_next;
   assign r0_rd_valid = rd_phase & ~owner_q & app_rd_valid;
   assign r1_rd_valid = rd_phase & owner_q & app_rd_valid;
   assign r0_rd_data  = app_rd_data;
   assign r1_rd_data  = app_rd_data;

endmodule

// File: tb/tb_sdrc_req_arb.sv
// tb_sdrc_req_arb: random two-requester traffic against sdrc_req_arb,
// with a reference model feeding scoreboard queues and a negedge monitor.
module tb_sdrc_req_arb;

   typedef struct packed {
      logic [29:0] addr;
      logic [8:0]  len;
      logic        wr_n;
      logic        dma;
   } req_t;

   typedef struct packed {
      logic        port;
      logic        is_wr;
      logic [31:0] data;
   } beat_t;

   typedef struct packed {
      logic       req;
      logic [3:0] en;
   } cyc_t;

   localparam int NCYC  = 3000;
   localparam int DRAIN = 3000;

   logic        clk = 1'b0;
   logic        reset;
   logic        rq [2];
   req_t        fld [2];
   logic [31:0] wdat [2];
   logic [3:0]  wen [2];
   logic        app_req_ack, app_wr_next, app_rd_valid;
   logic [31:0] app_rd_data;

   logic        r0_req_ack, r1_req_ack, r0_wr_next, r1_wr_next;
   logic        r0_rd_valid, r1_rd_valid, app_req, app_req_wr_n;
   logic        app_req_dma_last;
   logic [31:0] r0_rd_data, r1_rd_data, app_wr_data;
   logic [29:0] app_req_addr;
   logic [8:0]  app_req_len;
   logic [3:0]  app_wr_en_n;

   req_t  q_req [$];
   logic  q_ack [$];
   beat_t q_beat [$];
   cyc_t  q_cyc [$];

   int total = 0;
   int bad = 0;
   bit started = 0;

   always #5 clk = ~clk;

   sdrc_req_arb dut (
      .clk(clk), .reset(reset),
      .r0_req(rq[0]), .r0_req_addr(fld[0].addr),
      .r0_req_len(fld[0].len), .r0_req_wr_n(fld[0].wr_n),
      .r0_req_dma_last(fld[0].dma), .r0_req_ack(r0_req_ack),
      .r0_wr_data(wdat[0]), .r0_wr_en_n(wen[0]),
      .r0_wr_next(r0_wr_next), .r0_rd_data(r0_rd_data),
      .r0_rd_valid(r0_rd_valid),
      .r1_req(rq[1]), .r1_req_addr(fld[1].addr),
      .r1_req_len(fld[1].len), .r1_req_wr_n(fld[1].wr_n),
      .r1_req_dma_last(fld[1].dma), .r1_req_ack(r1_req_ack),
      .r1_wr_data(wdat[1]), .r1_wr_en_n(wen[1]),
      .r1_wr_next(r1_wr_next), .r1_rd_data(r1_rd_data),
      .r1_rd_valid(r1_rd_valid),
      .app_req(app_req), .app_req_addr(app_req_addr),
      .app_req_len(app_req_len), .app_req_wr_n(app_req_wr_n),
      .app_req_dma_last(app_req_dma_last), .app_req_ack(app_req_ack),
      .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
      .app_wr_next(app_wr_next), .app_rd_data(app_rd_data),
      .app_rd_valid(app_rd_valid)
   );

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: pops expectations whenever the DUT shows an event.
   logic prev_req = 1'b0;
   always @(negedge clk) begin
      if (started) begin
         cyc_t c;
         if (q_cyc.size() == 0) begin
            chk("cyc_underrun", 1, 0);
         end else begin
            c = q_cyc.pop_front();
            chk("app_req", {63'd0, app_req}, {63'd0, c.req});
            chk("app_wr_en_n", {60'd0, app_wr_en_n}, {60'd0, c.en});
         end
         if (app_req && !prev_req) begin
            if (q_req.size() == 0) chk("unexp_app_req", 1, 0);
            else begin
               req_t r;
               r = q_req.pop_front();
               chk("req_fields",
                   {23'd0, app_req_addr, app_req_len, app_req_wr_n,
                    app_req_dma_last},
                   {23'd0, r});
            end
         end
         prev_req = app_req;
         if (r0_req_ack || r1_req_ack) begin
            chk("ack_onehot", {63'd0, r0_req_ack & r1_req_ack}, 0);
            if (q_ack.size() == 0) chk("unexp_ack", 1, 0);
            else chk("ack_port", {63'd0, r1_req_ack},
                     {63'd0, q_ack.pop_front()});
         end
         for (int n = 0; n < 2; n++) begin
            logic wn, rv;
            logic [31:0] rd;
            wn = n ? r1_wr_next : r0_wr_next;
            rv = n ? r1_rd_valid : r0_rd_valid;
            rd = n ? r1_rd_data : r0_rd_data;
            if (wn && rv) chk("wr_and_rd", 1, 0);
            if (wn || rv) begin
               if (q_beat.size() == 0) chk("unexp_beat", n, 99);
               else begin
                  beat_t b;
                  b = q_beat.pop_front();
                  chk("beat_port", n, {63'd0, b.port});
                  chk("beat_kind", {63'd0, wn}, {63'd0, b.is_wr});
                  chk("beat_data", {32'd0, wn ? app_wr_data : rd},
                      {32'd0, b.data});
               end
            end
         end
      end
   end

   // Reference model: 0 idle, 1 request shown, 2 data phase.
   int   ph = 0;
   logic own = 0;
   logic last = 1;
   int   left = 0;
   req_t cur;
   bit   pend [2] = '{0, 0};
   bit   wd [2] = '{0, 0};

   initial begin
      bit did_rst = 0;
      bit force_both = 0;
      bit stop;
      reset = 1'b1;
      app_req_ack = 0; app_wr_next = 0; app_rd_valid = 0;
      app_rd_data = '0;
      for (int n = 0; n < 2; n++) begin
         rq[n] = 0; fld[n] = '0; wdat[n] = '0; wen[n] = '1;
      end
      cur = '0;
      @(posedge clk); #1;
      started = 1;
      for (int c = 0; c < NCYC + DRAIN; c++) begin
         bit rst_now, ack, bt;
         logic g;
         stop = (c >= NCYC);
         if (stop && ph == 0 && !pend[0] && !pend[1]) break;
         if (c == 2) force_both = 1;
         rst_now = (c < 2);
         if (!did_rst && c > 200 && ph == 2 && own && left >= 2) begin
            rst_now = 1; did_rst = 1; force_both = 1;
         end
         for (int n = 0; n < 2; n++) begin
            if (!rst_now && !stop && !pend[n] &&
                (force_both || $urandom_range(0, 3) == 0)) begin
               pend[n] = 1; wd[n] = 0;
               fld[n].addr = 30'($urandom);
               fld[n].len = ($urandom_range(0, 9) == 0) ?
                            9'($urandom_range(8, 40)) :
                            9'($urandom_range(0, 7));
               fld[n].wr_n = 1'($urandom_range(0, 1));
               fld[n].dma = 1'($urandom_range(0, 1));
            end
            wdat[n] = $urandom;
            wen[n] = 4'($urandom);
         end
         if (pend[0] && pend[1]) force_both = 0;
         if (ph == 1 && !wd[own] && $urandom_range(0, 3) == 0)
            wd[own] = 1;
         for (int n = 0; n < 2; n++) rq[n] = pend[n] && !wd[n];
         ack = !rst_now && ph == 1 && ($urandom_range(0, 1) == 1);
         bt = !rst_now && ((ph == 2) ? ($urandom_range(0, 2) != 0)
                                     : ($urandom_range(0, 7) == 0));
         app_req_ack = ack;
         app_rd_data = $urandom;
         if (ph == 2) begin
            app_wr_next  = bt && !cur.wr_n;
            app_rd_valid = bt && cur.wr_n;
         end else begin
            app_wr_next  = bt && $urandom_range(0, 1);
            app_rd_valid = bt && !app_wr_next;
         end
         q_cyc.push_back('{req: (ph == 1),
                           en: (ph == 2 && !cur.wr_n) ? wen[own] : 4'hF});
         if (ack) q_ack.push_back(own);
         if (ph == 2 && bt)
            q_beat.push_back('{port: own, is_wr: !cur.wr_n,
                               data: cur.wr_n ? app_rd_data : wdat[own]});
         if (rst_now) begin
            ph = 0; last = 1;
         end else if (ph == 0) begin
            if (rq[0] || rq[1]) begin
               g = (rq[0] && rq[1]) ? !last : rq[1];
               own = g; cur = fld[g];
               q_req.push_back(cur);
               ph = 1;
            end
         end else if (ph == 1) begin
            if (ack) begin
               pend[own] = 0; wd[own] = 0;
               left = (cur.len == 0) ? 1 : int'(cur.len);
               ph = 2;
            end
         end else if (bt) begin
            left--;
            if (left == 0) begin
               ph = 0; last = own;
            end
         end
         reset = rst_now;
         @(posedge clk); #1;
      end
      started = 0;
      app_req_ack = 0; app_wr_next = 0; app_rd_valid = 0;
      rq[0] = 0; rq[1] = 0;
      chk("drained", {63'd0, (ph == 0 && !pend[0] && !pend[1])}, 1);
      chk("q_req_empty", q_req.size(), 0);
      chk("q_ack_empty", q_ack.size(), 0);
      chk("q_beat_empty", q_beat.size(), 0);
      chk("q_cyc_empty", q_cyc.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
